// File: rtl/bus_width_decrease.sv
// bus_width_decrease: valid/ready width-down serializer, LSB slice first.
// Ports: clk, reset (async low), input_valid/ready/data_in, output_valid/ready/data_out.
module bus_width_decrease #(
  parameter int SIZE_IN  = 32,
  parameter int SIZE_OUT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                input_valid,
  output logic                input_ready,
  input  logic [SIZE_IN-1:0]  data_in,
  output logic                output_valid,
  input  logic                output_ready,
  output logic [SIZE_OUT-1:0] data_out
);

  localparam int RATIO = SIZE_IN / SIZE_OUT;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  if ((SIZE_IN % SIZE_OUT) != 0 || SIZE_IN < SIZE_OUT) begin : g_bad_ratio
    $error("SIZE_IN must be a multiple of SIZE_OUT");
  end

  typedef logic [RATIO-1:0][SIZE_OUT-1:0] word_t;

  word_t            data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             last;
  logic             in_fire;
  logic             out_fire;

  assign last     = (cnt_q == CNT_W'(RATIO - 1));
  // Reload allowed while the last beat leaves: no bubble between words.
  assign input_ready  = reset & (~full_q | (output_ready & last));
  assign in_fire      = input_valid & input_ready;
  assign out_fire     = full_q & output_ready;
  assign output_valid = full_q;
  assign data_out     = data_q[cnt_q];

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    full_d = full_q;
    unique case (1'b1)
      in_fire: begin
        data_d = data_in;
        cnt_d  = '0;
        full_d = 1'b1;
      end
      out_fire & last & ~in_fire: begin
        cnt_d  = '0;
        full_d = 1'b0;
      end
      out_fire & ~last: begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

endmodule

// File: tb/tb_bus_width_decrease.sv
// tb_bus_width_decrease: directed checks for the width-down serializer.
// Covers reset, stalls, back-to-back words, soak, RATIO=1 and 64->8.
module tb_bus_width_decrease;

  logic        clk;
  logic        reset;
  logic        iv, ir, ov, ordy;
  logic [31:0] din;
  logic [7:0]  dout;

  logic        iv1, ir1, ov1, or1;
  logic [15:0] din1, dout1;

  logic        iv8, ir8, ov8, or8;
  logic [63:0] din8;
  logic [7:0]  dout8;

  int n_cmp = 0;
  int n_bad = 0;

  bus_width_decrease #(.SIZE_IN(32), .SIZE_OUT(8)) u_dut (
    .clk(clk), .reset(reset),
    .input_valid(iv), .input_ready(ir), .data_in(din),
    .output_valid(ov), .output_ready(ordy), .data_out(dout)
  );

  bus_width_decrease #(.SIZE_IN(16), .SIZE_OUT(16)) u_r1 (
    .clk(clk), .reset(reset),
    .input_valid(iv1), .input_ready(ir1), .data_in(din1),
    .output_valid(ov1), .output_ready(or1), .data_out(dout1)
  );

  bus_width_decrease #(.SIZE_IN(64), .SIZE_OUT(8)) u_r8 (
    .clk(clk), .reset(reset),
    .input_valid(iv8), .input_ready(ir8), .data_in(din8),
    .output_valid(ov8), .output_ready(or8), .data_out(dout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0]  sb [4];
    logic [7:0]  bb [7];
    logic        rp [7];
    logic        ie [7];
    logic [31:0] q [$];
    logic [31:0] acc;
    logic [31:0] expw;
    logic        fi, fo;
    int          sent, got, cyc, nb;

    sb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    rp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bb = '{8'hAA, 8'hBB, 8'hBB, 8'hBB, 8'hCC, 8'hDD, 8'hDD};
    ie = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b0;
    iv = 1'b0; ordy = 1'b0; din = 'x;
    iv1 = 1'b0; or1 = 1'b0; din1 = '0;
    iv8 = 1'b0; or8 = 1'b0; din8 = '0;

    // reset held
    step(); step();
    chk("rst_ov", ov, 0);
    chk("rst_ir", ir, 0);
    chk("rst_dout", dout, 0);
    reset = 1'b1;
    #1;
    chk("idle_ir", ir, 1);
    chk("idle_ov", ov, 0);
    step();
    chk("idle_x_dout", dout, 0);
    chk("idle_ov2", ov, 0);

    // single word, consumer always ready
    din = 32'hDDCCBBAA; iv = 1'b1; ordy = 1'b1;
    #1;
    chk("s_ir_load", ir, 1);
    step();
    iv = 1'b0; din = 'x;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("s_ov", ov, 1);
      chk("s_dout", dout, sb[i]);
      chk("s_ir", ir, (i == 3));
      step();
    end
    chk("s_done_ov", ov, 0);

    // backpressure pattern 1,0,0,1,1,0,1
    din = 32'hDDCCBBAA; iv = 1'b1; ordy = 1'b0;
    step();
    iv = 1'b0; din = 'x;
    for (int i = 0; i < 7; i++) begin
      ordy = rp[i];
      #1;
      chk("bp_ov", ov, 1);
      chk("bp_dout", dout, bb[i]);
      chk("bp_ir", ir, ie[i]);
      step();
    end
    chk("bp_done_ov", ov, 0);

    // back-to-back words, no bubble
    ordy = 1'b1; din = 32'h03020100; iv = 1'b1;
    #1;
    chk("b_ir0", ir, 1);
    step();
    din = 32'h07060504;
    for (int i = 0; i < 8; i++) begin
      iv = (i < 4);
      #1;
      chk("b_ov", ov, 1);
      chk("b_dout", dout, i);
      chk("b_ir", ir, (i == 3 || i == 7));
      step();
    end
    chk("b_done_ov", ov, 0);
    iv = 1'b0; din = 'x;

    // asynchronous reset in the middle of a word
    din = 32'h44332211; iv = 1'b1; ordy = 1'b1;
    step();
    iv = 1'b0; din = 'x;
    chk("mr_b0", dout, 8'h11);
    step();
    chk("mr_b1", dout, 8'h22);
    #2 reset = 1'b0;
    #1;
    chk("mr_ov", ov, 0);
    chk("mr_ir", ir, 0);
    chk("mr_dout", dout, 0);
    step();
    reset = 1'b1;
    step(); step();
    chk("mr_ov_after", ov, 0);
    chk("mr_dout_after", dout, 0);

    // random soak with scoreboard
    sent = 0; got = 0; cyc = 0; nb = 0; acc = '0;
    iv = 1'b0; ordy = 1'b0;
    while (got < 100 && cyc < 5000) begin
      if (!iv && sent < 100 && $urandom_range(0, 2) != 0) begin
        iv = 1'b1;
        din = $urandom;
      end
      if (cyc % 5 == 0 || $urandom_range(0, 3) == 0) ordy = 1'b1;
      #1;
      fi = iv & ir;
      fo = ov & ordy;
      if (fi) begin
        q.push_back(din);
        sent++;
      end
      if (fo) begin
        acc[nb*8 +: 8] = dout;
        nb++;
        if (nb == 4) begin
          expw = (q.size() > 0) ? q.pop_front() : 'x;
          chk("soak_word", acc, expw);
          got++;
          nb = 0;
        end
      end
      step();
      if (fi) begin
        iv = 1'b0;
        din = 'x;
      end
      if (fo) ordy = 1'b0;
      cyc++;
    end
    chk("soak_count", got, 100);
    iv = 1'b0; ordy = 1'b0;

    // RATIO = 1 register slice
    iv1 = 1'b1; din1 = 16'hBEEF; or1 = 1'b1;
    #1;
    chk("r1_ir", ir1, 1);
    step();
    din1 = 16'h1234;
    #1;
    chk("r1_ov", ov1, 1);
    chk("r1_d0", dout1, 16'hBEEF);
    chk("r1_ir2", ir1, 1);
    step();
    iv1 = 1'b0;
    #1;
    chk("r1_ov2", ov1, 1);
    chk("r1_d1", dout1, 16'h1234);
    step();
    chk("r1_done", ov1, 0);

    // 64 -> 8, eight beats LSB first
    din8 = 64'hF7F6F5F4F3F2F1F0; iv8 = 1'b1; or8 = 1'b1;
    step();
    iv8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("r8_ov", ov8, 1);
      chk("r8_dout", dout8, 8'hF0 + i);
      chk("r8_ir", ir8, (i == 7));
      step();
    end
    chk("r8_done", ov8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_width_decrease.md
Name: bus_width_decrease

Overview:
- Width-down converter (serializer) on a valid/ready streaming path.
- Accepts one SIZE_IN-bit word per input handshake and emits it as SIZE_IN/SIZE_OUT consecutive SIZE_OUT-bit beats on the output handshake, least-significant slice first.
- Sits between a wide producer and a narrow consumer.
- Full-throughput: back-to-back words produce one output beat per cycle with no bubbles.

Parameters:
- SIZE_IN, 32, input word width in bits; must be an integer multiple of SIZE_OUT (elaboration error otherwise).
- SIZE_OUT, 8, output beat width in bits.
- Derived RATIO = SIZE_IN/SIZE_OUT (RATIO ≥ 1); CNT_W = max(1, clog2(RATIO)).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- input_valid  input  1  producer has a word on data_in.
- input_ready  output  1  block can accept data_in this cycle.
- data_in  input  SIZE_IN  wide input word.
- output_valid  output  1  data_out holds a valid beat.
- output_ready  input  1  consumer accepts data_out this cycle.
- data_out  output  SIZE_OUT  current narrow beat.

Behaviour:
- State:
  - hold register data_q[SIZE_IN]
  - beat counter cnt[CNT_W]
  - full flag
- Input fire = input_valid & input_ready; output fire = output_valid & output_ready.
- output_valid = full.
- data_out = data_q[cnt*SIZE_OUT +: SIZE_OUT], i.e. beat k = bits [k*SIZE_OUT+SIZE_OUT-1 : k*SIZE_OUT].
- input_ready = reset & (!full | (output_ready & cnt == RATIO-1)).
  - Combinational path output_ready -> input_ready is intentional; it enables zero-bubble reload on the last beat.
- Reset asserted (reset=0, asynchronous):
  - full=0, cnt=0, data_q=0.
  - output_valid=0, data_out=0, input_ready=0 for as long as reset is low.
- After reset deasserts: input_ready=1, output_valid=0.
- Reset mid-word: the partial word is discarded; no beats of it appear after reset.
- Input fire (with no concurrent last-beat output fire): data_q<=data_in, cnt<=0, full<=1. First beat is presented the following cycle (latency 1 cycle from input handshake to output_valid).
- Output fire with cnt < RATIO-1: cnt<=cnt+1; data_q unchanged.
- Output fire with cnt == RATIO-1:
  - If input fire in the same cycle: data_q<=data_in, cnt<=0, full stays 1 (no bubble).
  - Otherwise: full<=0, cnt<=0.
- Stall: while output_valid=1 and output_ready=0, data_out and cnt hold stable; input_ready=0 if full.
- input_valid while input_ready=0 has no effect; data_in is ignored.
- RATIO=1: behaves as a one-deep register slice; every beat is the last beat.
- Ordering: beats of word N are all emitted before any beat of word N+1; no word is dropped or duplicated.
- Throughput: with input_valid and output_ready held high, one output beat per cycle; one input accepted every RATIO cycles.
- X on data_in while input_valid=0 must not propagate into data_q.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release -> output_valid=0, data_out=0, input_ready=1; assert reset mid-stream -> output_valid drops to 0 immediately (async).
- Single word, output_ready=1: data_in=32'hDDCCBBAA, input_valid=1 for one cycle -> beats AA, BB, CC, DD on 4 consecutive cycles; input_ready low during beats 1-3 and high on the DD cycle; output_valid=0 afterwards.
- Backpressure: same word, output_ready toggled 1,0,0,1,1,0,1 -> exactly AA, BB, CC, DD delivered; data_out stable on every stalled cycle.
- Back-to-back words: 32'h03020100 then 32'h07060504 with input_valid and output_ready held 1 -> data_out sequence 00..07 on 8 consecutive cycles with no gap; second word accepted on the cycle showing 03.
- Random soak: 100+ random words, random output_ready pulses (e.g. asserted every 5th cycle, dropped after each accepted beat) -> scoreboard reassembles 4 beats LSB-first and matches every accepted input word in order.
- Parameter sweep: SIZE_IN=16/SIZE_OUT=16 (RATIO=1) and SIZE_IN=64/SIZE_OUT=8 -> pass-through with 1-cycle latency, and 8-beat LSB-first serialization respectively.
